// File: rtl/peripheral_mpram_arb_if.sv
// Requester-side bus of the multi-port RAM arbiter: flat per-port request and response vectors.
interface peripheral_mpram_arb_if #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 32,
  parameter int unsigned PORTS = 4
);
  localparam int unsigned NB = DW / 8;

  logic [PORTS-1:0]    ram_req;
  logic [PORTS-1:0]    ram_we;
  logic [PORTS*NB-1:0] ram_be;
  logic [PORTS*AW-1:0] ram_addr;
  logic [PORTS*DW-1:0] ram_wdata;
  logic [PORTS-1:0]    ram_gnt;
  logic [PORTS-1:0]    ram_rvalid;
  logic [PORTS*DW-1:0] ram_rdata;
  logic [PORTS-1:0]    ram_err;

  modport master (
    output ram_req, ram_we, ram_be, ram_addr, ram_wdata,
    input  ram_gnt, ram_rvalid, ram_rdata, ram_err
  );

  modport slave (
    input  ram_req, ram_we, ram_be, ram_addr, ram_wdata,
    output ram_gnt, ram_rvalid, ram_rdata, ram_err
  );
endinterface

// File: rtl/peripheral_mpram_arb.sv
// Single-ported word RAM shared by PORTS requesters through a round-robin arbiter, 1-cycle response.
// Optional PERIPHERAL_MPRAM_ADDR_CHECK_EN: flag out-of-range accesses on ram_err and return zero data.
module peripheral_mpram_arb #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned PORTS = 4
) (
  input  logic                          ram_clk,
  input  logic                          ram_rst,
  peripheral_mpram_arb_if.slave         bus
);
  localparam int unsigned NB  = DW / 8;
  localparam int unsigned PW  = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int unsigned MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PORTS-1:0] gnt_c;
  logic [PW-1:0]    gnt_idx_c;
  logic             gnt_any_c;

  logic [AW-1:0]    addr_a  [PORTS];
  logic [NB-1:0]    be_a    [PORTS];
  logic [DW-1:0]    wdata_a [PORTS];

  logic [AW-1:0]    addr_c;
  logic [NB-1:0]    be_c;
  logic [DW-1:0]    wdata_c;
  logic             we_c;
  logic             in_range_c;
  logic [MAW-1:0]   idx_c;

  logic [DW-1:0]    mem [DEPTH];

  logic [PORTS-1:0] rvalid_q, rvalid_d;
  logic [PORTS-1:0] err_q, err_d;
  logic [DW-1:0]    rdata_q [PORTS];
  logic [DW-1:0]    rdata_d [PORTS];

  // Unpack the flat bus into per-port views
  for (genvar g = 0; g < PORTS; g++) begin : g_port
    assign addr_a[g]  = bus.ram_addr[g*AW +: AW];
    assign be_a[g]    = bus.ram_be[g*NB +: NB];
    assign wdata_a[g] = bus.ram_wdata[g*DW +: DW];
    assign bus.ram_rdata[g*DW +: DW] = rdata_q[g];
  end

  assign bus.ram_gnt    = gnt_c;
  assign bus.ram_rvalid = rvalid_q;
  assign bus.ram_err    = err_q;

  // Round-robin search starting at the priority pointer
  always_comb begin
    int unsigned p;
    gnt_c     = '0;
    gnt_idx_c = '0;
    gnt_any_c = 1'b0;
    p         = 0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      p = 32'(ptr_q) + k;
      if (p >= PORTS) p = p - PORTS;
      if (!gnt_any_c && !ram_rst && bus.ram_req[PW'(p)]) begin
        gnt_any_c        = 1'b1;
        gnt_c[PW'(p)]    = 1'b1;
        gnt_idx_c        = PW'(p);
      end
    end
  end

  always_comb begin
    addr_c     = addr_a[gnt_idx_c];
    be_c       = be_a[gnt_idx_c];
    wdata_c    = wdata_a[gnt_idx_c];
    we_c       = bus.ram_we[gnt_idx_c];
    in_range_c = ({1'b0, addr_c} < DEPTH_W);
    idx_c      = MAW'(addr_c);
  end

  // Next pointer and response generation
  always_comb begin
    ptr_d    = ptr_q;
    rvalid_d = '0;
    err_d    = '0;
    rdata_d  = rdata_q;
    if (gnt_any_c) begin
      ptr_d = (gnt_idx_c == PW'(PORTS-1)) ? '0 : PW'(gnt_idx_c + PW'(1));
      rvalid_d[gnt_idx_c] = 1'b1;
`ifdef PERIPHERAL_MPRAM_ADDR_CHECK_EN
      err_d[gnt_idx_c] = !in_range_c;
`endif
      if (!we_c) rdata_d[gnt_idx_c] = in_range_c ? mem[idx_c] : '0;
    end
  end

  always_ff @(posedge ram_clk or posedge ram_rst) begin
    if (ram_rst) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      for (int unsigned i = 0; i < PORTS; i++) rdata_q[i] <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      for (int unsigned i = 0; i < PORTS; i++) rdata_q[i] <= rdata_d[i];
    end
  end

  // Array contents are intentionally not reset; out-of-range writes never land
  always_ff @(posedge ram_clk) begin
    if (gnt_any_c && we_c && in_range_c) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (be_c[b]) mem[idx_c][b*8 +: 8] <= wdata_c[b*8 +: 8];
      end
    end
  end
endmodule

// File: tb/tb_peripheral_mpram_arb.sv
// Directed bench for peripheral_mpram_arb: arbitration order, byte writes, read latency, reset, range.
module tb_peripheral_mpram_arb;
  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned PORTS = 4;
`ifdef PERIPHERAL_MPRAM_ADDR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic ram_clk;
  logic ram_rst;
  int   checks;
  int   failures;

  peripheral_mpram_arb_if #(.AW(AW), .DW(DW), .PORTS(PORTS)) bus ();

  peripheral_mpram_arb #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .PORTS(PORTS)) dut (
    .ram_clk (ram_clk),
    .ram_rst (ram_rst),
    .bus     (bus)
  );

  initial ram_clk = 1'b0;
  always #5 ram_clk = ~ram_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic req, input logic we, input logic [3:0] be,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ram_req[p]              = req;
    bus.ram_we[p]               = we;
    bus.ram_be[p*4 +: 4]        = be;
    bus.ram_addr[p*AW +: AW]    = a;
    bus.ram_wdata[p*DW +: DW]   = d;
  endtask

  task automatic cycle();
    @(posedge ram_clk);
    @(negedge ram_clk);
  endtask

  function automatic logic [DW-1:0] rd(input int p);
    return bus.ram_rdata[p*DW +: DW];
  endfunction

  initial begin
    logic [3:0] e_rv;
    logic [3:0] e_g;
    checks   = 0;
    failures = 0;
    ram_rst  = 1'b1;
    bus.ram_req   = '0;
    bus.ram_we    = '0;
    bus.ram_be    = '0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    for (int p = 0; p < 4; p++) drive(p, 1'b1, 1'b0, 4'h0, AW'(p), 32'h0);
    repeat (2) @(negedge ram_clk);

    // Reset state with all ports requesting
    chk("rst_gnt",    64'(bus.ram_gnt),    64'h0);
    chk("rst_rvalid", 64'(bus.ram_rvalid), 64'h0);
    chk("rst_err",    64'(bus.ram_err),    64'h0);
    chk("rst_rdata0", 64'(rd(0)),          64'h0);

    // Continuous requests from all ports: 0,1,2,3,0,...
    ram_rst = 1'b0;
    #1 chk("rr_gnt_first", 64'(bus.ram_gnt), 64'h1);
    for (int k = 0; k < 8; k++) begin
      cycle();
      e_rv = 4'b0001 << (k % 4);
      e_g  = 4'b0001 << ((k + 1) % 4);
      chk("rr_rvalid", 64'(bus.ram_rvalid), 64'(e_rv));
      chk("rr_gnt",    64'(bus.ram_gnt),    64'(e_g));
    end
    bus.ram_req = '0;
    #1 chk("idle_gnt", 64'(bus.ram_gnt), 64'h0);
    cycle();
    chk("idle_rvalid", 64'(bus.ram_rvalid), 64'h0);

    // Full write then read, latency one
    drive(0, 1'b1, 1'b1, 4'hF, 9'h010, 32'hDEADBEEF);
    #1 chk("wr_gnt", 64'(bus.ram_gnt), 64'h1);
    cycle();
    chk("wr_ack", 64'(bus.ram_rvalid), 64'h1);
    chk("wr_err", 64'(bus.ram_err),    64'h0);
    drive(0, 1'b1, 1'b0, 4'h0, 9'h010, 32'h0);
    #1 chk("rd_gnt", 64'(bus.ram_gnt), 64'h1);
    cycle();
    chk("rd_rvalid", 64'(bus.ram_rvalid), 64'h1);
    chk("rd_data",   64'(rd(0)),          64'hDEADBEEF);
    drive(0, 1'b0, 1'b0, 4'h0, 9'h010, 32'h0);
    cycle();
    chk("rd_pulse_once", 64'(bus.ram_rvalid), 64'h0);
    chk("rd_hold",       64'(rd(0)),          64'hDEADBEEF);

    // Byte-lane merge, zero-lane no-op, read right after write
    drive(0, 1'b1, 1'b1, 4'hF, 9'h020, 32'h11223344);
    cycle();
    drive(0, 1'b1, 1'b1, 4'h2, 9'h020, 32'h0000AA00);
    cycle();
    chk("be_ack",         64'(bus.ram_rvalid), 64'h1);
    chk("wr_keeps_rdata", 64'(rd(0)),          64'hDEADBEEF);
    drive(0, 1'b1, 1'b1, 4'h0, 9'h020, 32'hFFFFFFFF);
    cycle();
    drive(0, 1'b1, 1'b0, 4'h0, 9'h020, 32'h0);
    cycle();
    chk("be_merge", 64'(rd(0)), 64'h1122AA44);

    // Another port reads while port 0 keeps its last data
    drive(0, 1'b0, 1'b0, 4'h0, 9'h020, 32'h0);
    drive(3, 1'b1, 1'b0, 4'h0, 9'h010, 32'h0);
    cycle();
    chk("p3_rvalid", 64'(bus.ram_rvalid), 64'h8);
    chk("p3_rdata",  64'(rd(3)),          64'hDEADBEEF);
    chk("p0_hold",   64'(rd(0)),          64'h1122AA44);

    // Out-of-range write must not alias onto 0x010
    drive(3, 1'b0, 1'b0, 4'h0, 9'h010, 32'h0);
    drive(1, 1'b1, 1'b1, 4'hF, 9'h110, 32'hCAFEF00D);
    cycle();
    chk("oor_wr_ack", 64'(bus.ram_rvalid), 64'h2);
    chk("oor_wr_err", 64'(bus.ram_err),    ERR_EN ? 64'h2 : 64'h0);
    drive(1, 1'b1, 1'b0, 4'h0, 9'h010, 32'h0);
    cycle();
    chk("oor_no_alias", 64'(rd(1)), 64'hDEADBEEF);
`ifdef PERIPHERAL_MPRAM_ADDR_CHECK_EN
    drive(1, 1'b1, 1'b0, 4'h0, 9'h100, 32'h0);
    cycle();
    chk("oor_rd_rvalid", 64'(bus.ram_rvalid), 64'h2);
    chk("oor_rd_err",    64'(bus.ram_err),    64'h2);
    chk("oor_rd_data",   64'(rd(1)),          64'h0);
`endif

    // Reset right after a read grant drops the response
    drive(1, 1'b0, 1'b0, 4'h0, 9'h010, 32'h0);
    drive(2, 1'b1, 1'b0, 4'h0, 9'h010, 32'h0);
    #1 chk("prerst_gnt", 64'(bus.ram_gnt), 64'h4);
    @(posedge ram_clk);
    #1 ram_rst = 1'b1;
    #1;
    chk("midrst_rvalid", 64'(bus.ram_rvalid), 64'h0);
    chk("midrst_err",    64'(bus.ram_err),    64'h0);
    chk("midrst_rdata0", 64'(rd(0)),          64'h0);
    chk("midrst_rdata3", 64'(rd(3)),          64'h0);
    chk("midrst_gnt",    64'(bus.ram_gnt),    64'h0);
    drive(0, 1'b1, 1'b0, 4'h0, 9'h010, 32'h0);
    @(negedge ram_clk);
    chk("midrst_rvalid_hold", 64'(bus.ram_rvalid), 64'h0);
    ram_rst = 1'b0;
    #1 chk("postrst_gnt", 64'(bus.ram_gnt), 64'h1);
    cycle();
    chk("postrst_rvalid", 64'(bus.ram_rvalid), 64'h1);
    chk("postrst_rdata",  64'(rd(0)),          64'hDEADBEEF);

    // Sparse requesters 1 and 3 from pointer 0: no idle cycles
    bus.ram_req = '0;
    ram_rst     = 1'b1;
    drive(1, 1'b1, 1'b0, 4'h0, 9'h010, 32'h0);
    drive(3, 1'b1, 1'b0, 4'h0, 9'h020, 32'h0);
    #1 chk("sparse_rst_gnt", 64'(bus.ram_gnt), 64'h0);
    @(negedge ram_clk);
    ram_rst = 1'b0;
    #1 chk("sparse_gnt_first", 64'(bus.ram_gnt), 64'h2);
    for (int k = 0; k < 4; k++) begin
      cycle();
      e_rv = (k % 2 == 0) ? 4'b0010 : 4'b1000;
      e_g  = (k % 2 == 0) ? 4'b1000 : 4'b0010;
      chk("sparse_rvalid", 64'(bus.ram_rvalid), 64'(e_rv));
      chk("sparse_gnt",    64'(bus.ram_gnt),    64'(e_g));
    end
    chk("sparse_rdata1", 64'(rd(1)), 64'hDEADBEEF);
    chk("sparse_rdata3", 64'(rd(3)), 64'h1122AA44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/peripheral_mpram_arb.md
PERIPHERAL_MPRAM_ARB -- requirements
Module: peripheral_mpram_arb

Interface
REQ-001 SHALL have parameter AW, default 8, word-address width.
REQ-002 SHALL have parameter DW, default 32, data width; a multiple of 8; byte lanes NB = DW/8.
REQ-003 SHALL have parameter DEPTH, default 256, number of words; DEPTH <= 2^AW.
REQ-004 SHALL have parameter PORTS, default 4, number of requester ports; PORTS >= 1.
REQ-005 SHALL have port ram_clk, input, 1, the single clock; all logic on rising edge.
REQ-006 SHALL have port ram_rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port ram_req, input, PORTS, per-port access request.
REQ-008 SHALL have port ram_we, input, PORTS, per-port write (1) / read (0).
REQ-009 SHALL have port ram_be, input, PORTS*NB, per-port byte-lane write enables (active high).
REQ-010 SHALL have port ram_addr, input, PORTS*AW, per-port word address.
REQ-011 SHALL have port ram_wdata, input, PORTS*DW, per-port write data.
REQ-012 SHALL have port ram_gnt, output, PORTS, one-hot grant, combinational from ram_req and priority pointer.
REQ-013 SHALL have port ram_rvalid, output, PORTS, per-port read-response strobe.
REQ-014 SHALL have port ram_rdata, output, PORTS*DW, per-port read data.
REQ-015 SHALL have port ram_err, output, PORTS, per-port out-of-range strobe, aligned with ram_rvalid.

Function
REQ-016 SHALL store DEPTH words of DW bits in a single-access-per-cycle array; contents not reset.
REQ-017 SHALL grant at most one port per cycle, round-robin: port with highest priority is pointer P, then P+1 ... wrapping PORTS-1 -> 0.
REQ-018 SHALL, after a grant to port i, set P = (i+1) mod PORTS at the clock edge; P unchanged when no request.
REQ-019 SHALL perform the granted access at the clock edge where ram_gnt[i] and ram_req[i] are both high.
REQ-020 SHALL, on a granted write, update only lanes with ram_be bit set; ram_be all-zero is a granted no-op.
REQ-021 SHALL, on a granted read, drive ram_rdata slice i and pulse ram_rvalid[i] for exactly one cycle, one cycle after the grant edge (latency 1).
REQ-022 SHALL hold each ram_rdata slice until that port's next read response.
REQ-023 SHALL pulse ram_rvalid[i] for granted writes as well (write acknowledge); ram_rdata unchanged on writes.
REQ-024 SHALL return newly written data for a read granted in the cycle after a write to the same address.
REQ-025 Requesters SHALL hold ram_req, ram_we, ram_be, ram_addr, ram_wdata stable until granted; module need not check.
REQ-026 SHALL keep ram_gnt all-zero when ram_req is all-zero and while ram_rst is high.

Reset
REQ-027 SHALL, on ram_rst assertion, immediately clear ram_rvalid, ram_err, ram_rdata to zero and set P = 0.
REQ-028 SHALL perform no array access and produce no response for any request coinciding with reset; a response pending at reset assertion is dropped.
REQ-029 SHALL grant on the first rising edge after ram_rst deasserts, port 0 highest priority.

Configuration
REQ-030 With PERIPHERAL_MPRAM_ADDR_CHECK_EN defined, an access with address >= DEPTH SHALL be granted, SHALL NOT touch the array, and SHALL pulse ram_err[i] with ram_rvalid[i]; rdata slice driven to zero for reads.
REQ-031 Without PERIPHERAL_MPRAM_ADDR_CHECK_EN, ram_err SHALL be tied zero and out-of-range writes SHALL be dropped; out-of-range read data is undefined.

Verification
REQ-032 Port 0 write addr 0x10 data 0xDEADBEEF be 0xF, then read 0x10 -> rvalid[0] one cycle after grant, rdata 0xDEADBEEF.
REQ-033 Write 0x11223344 then be 0x2 data 0x0000AA00 to same address, read -> 0x1122AA44.
REQ-034 All four ports request continuously from reset -> grant order 0,1,2,3,0,...; each port one grant per 4 cycles.
REQ-035 Only ports 1 and 3 request, P=0 -> grants 1,3,1,3; no idle cycles.
REQ-036 Assert ram_rst in the cycle after a read grant -> rvalid never pulses, outputs zero, next grant after release goes to port 0.
REQ-037 With PERIPHERAL_MPRAM_ADDR_CHECK_EN, DEPTH=256, read address 0x100 -> rvalid and err pulse together, rdata 0, array unchanged.
